// File: rtl/kong_anim_ctrl_pkg.sv
// Shared Kong behaviour definitions: FSM encoding, LFSR constants and default sprite position.
package kong_anim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_WINDUP  = 3'd2,
    ST_THROW   = 3'd3,
    ST_RECOVER = 3'd4
  } kong_state_t;

  localparam logic [7:0] LFSR_SEED_DEF  = 8'hA5;
  localparam logic [7:0] LFSR_TAPS      = 8'hB8;  // q[7]^q[5]^q[4]^q[3]
  localparam logic [7:0] WAIT_RAND_MASK = 8'h3F;
  localparam logic [9:0] KONG_POSX      = 10'd20;
  localparam logic [8:0] KONG_POSY      = 9'd40;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/kong_anim_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR used to randomise Kong's idle time; steps once per frame tick.
module kong_lfsr8
  import kong_anim_ctrl_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)   r_q <= SEED;
    else if (en) r_q <= lfsr_next(r_q);
  end

  assign q = r_q;

endmodule

// File: rtl/kong_anim_ctrl.sv
// Kong behaviour FSM: idle/wait/wind-up/throw/recover, barrel spawn handshake and throw counter.
module kong_anim_ctrl
  import kong_anim_ctrl_pkg::*;
#(
  parameter logic [9:0] POSX           = KONG_POSX,
  parameter logic [8:0] POSY           = KONG_POSY,
  parameter int         IDLE_MIN       = 60,
  parameter int         WINDUP_FRAMES  = 30,
  parameter int         RECOVER_FRAMES = 15,
  parameter int         THROW_TIMEOUT  = 8,
  parameter logic [7:0] LFSR_SEED      = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       frame_tick,
  input  logic       isplay,
  input  logic       throw_ack,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       animation_state,
  output logic       kong_visible,
  output logic       throw_req,
  output logic [7:0] throw_count
);

  localparam logic [7:0] WINDUP_LAST  = 8'(WINDUP_FRAMES - 1);
  localparam logic [7:0] RECOVER_LAST = 8'(RECOVER_FRAMES - 1);
  localparam logic [7:0] THROW_LAST   = 8'(THROW_TIMEOUT - 1);

  kong_state_t r_state, w_next;
  logic [7:0]  r_frame_cnt;
  logic [7:0]  r_wait_len;
  logic [7:0]  r_throw_count;
  logic        r_pose, r_visible, r_req;
  logic [7:0]  w_lfsr;
  logic [7:0]  w_wait_len_new;
  logic        w_latch_wait;
  logic        w_count_inc;

  kong_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .clrn (clrn),
    .en   (frame_tick),
    .q    (w_lfsr)
  );

  // Pre-advance LFSR value: the tick on the latching edge does not affect this wait length.
  assign w_wait_len_new = 8'(IDLE_MIN) + (w_lfsr & WAIT_RAND_MASK);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next       = r_state;
    w_latch_wait = 1'b0;
    w_count_inc  = 1'b0;
    if (r_state != ST_IDLE && !isplay) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (isplay) begin
          w_next       = ST_WAIT;
          w_latch_wait = 1'b1;
        end
        ST_WAIT:   if (frame_tick && r_frame_cnt == r_wait_len - 8'd1) w_next = ST_WINDUP;
        ST_WINDUP: if (frame_tick && r_frame_cnt == WINDUP_LAST)       w_next = ST_THROW;
        ST_THROW: begin
          if (throw_ack) begin
            w_next      = ST_RECOVER;
            w_count_inc = 1'b1;
          end else if (frame_tick && r_frame_cnt == THROW_LAST) begin
            w_next = ST_RECOVER;
          end
        end
        ST_RECOVER: if (frame_tick && r_frame_cnt == RECOVER_LAST) begin
          w_next       = ST_WAIT;
          w_latch_wait = 1'b1;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state       <= ST_IDLE;
      r_frame_cnt   <= 8'd0;
      r_wait_len    <= 8'd0;
      r_throw_count <= 8'd0;
      r_pose        <= 1'b0;
      r_visible     <= 1'b0;
      r_req         <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_frame_cnt <= 8'd0;
      else if (frame_tick)   r_frame_cnt <= r_frame_cnt + 8'd1;
      if (w_latch_wait) r_wait_len    <= w_wait_len_new;
      if (w_count_inc)  r_throw_count <= r_throw_count + 8'd1;
      // Outputs are registered from the next state so they change on the transition edge.
      r_pose    <= (w_next == ST_WINDUP) || (w_next == ST_THROW);
      r_visible <= (w_next != ST_IDLE);
      r_req     <= (w_next == ST_THROW);
    end
  end

  assign posx            = POSX;
  assign posy            = POSY;
  assign animation_state = r_pose;
  assign kong_visible    = r_visible;
  assign throw_req       = r_req;
  assign throw_count     = r_throw_count;

endmodule

// File: tb/tb_kong_anim_ctrl.sv
// Scoreboard bench for kong_anim_ctrl: stimulus queues expected output changes, a monitor matches them.
module tb_kong_anim_ctrl;

  typedef struct packed {
    logic       vis;
    logic       pose;
    logic       req;
    logic [7:0] cnt;
  } obs_t;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       frame_tick = 1'b0;
  logic       isplay = 1'b0;
  logic       throw_ack = 1'b0;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       animation_state;
  logic       kong_visible;
  logic       throw_req;
  logic [7:0] throw_count;

  int   n_vec = 0;
  int   n_err = 0;
  obs_t exp_q[$];
  obs_t prev_obs = '0;
  obs_t mon_now;
  obs_t mon_exp;
  bit   mon_en = 1'b0;
  logic [7:0] m_lfsr = 8'hA5;
  logic [7:0] m_cnt = 8'd0;
  int   wl;

  always #5 clk = ~clk;

  kong_anim_ctrl dut (
    .clk             (clk),
    .clrn            (clrn),
    .frame_tick      (frame_tick),
    .isplay          (isplay),
    .throw_ack       (throw_ack),
    .posx            (posx),
    .posy            (posy),
    .animation_state (animation_state),
    .kong_visible    (kong_visible),
    .throw_req       (throw_req),
    .throw_count     (throw_count)
  );

  function automatic logic [7:0] model_next(input logic [7:0] q);
    logic fb;
    fb = q[7] ^ q[5] ^ q[4] ^ q[3];
    return {q[6:0], fb};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic expect_obs(input logic vis, input logic pose, input logic req);
    exp_q.push_back(obs_t'{vis, pose, req, m_cnt});
  endtask

  task automatic step(input bit tk, input bit ack);
    frame_tick = tk;
    throw_ack  = ack;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    throw_ack  = 1'b0;
    if (tk) m_lfsr = model_next(m_lfsr);
  endtask

  // From the WAIT entry edge: count out the wait, then the wind-up, ending in THROW.
  task automatic run_to_throw(input int wait_len, input bit stray_ack);
    for (int i = 0; i < wait_len - 1; i++) step(1'b1, stray_ack && (i == 0));
    expect_obs(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (29) step(1'b1, 1'b0);
    expect_obs(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0);
  endtask

  task automatic recover_to_wait(output int wait_len);
    repeat (14) step(1'b1, 1'b0);
    wait_len = 60 + int'(m_lfsr[5:0]);
    step(1'b1, 1'b0);
  endtask

  // Output changes are only legal where the stimulus announced one.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_now = obs_t'{kong_visible, animation_state, throw_req, throw_count};
      if (mon_now !== prev_obs) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change @%0t: got vis=%0b pose=%0b req=%0b cnt=%0d, expected no change",
                   $time, mon_now.vis, mon_now.pose, mon_now.req, mon_now.cnt);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_now !== mon_exp) begin
            n_err++;
            $display("FAIL output_change @%0t: got vis=%0b pose=%0b req=%0b cnt=%0d, expected vis=%0b pose=%0b req=%0b cnt=%0d",
                     $time, mon_now.vis, mon_now.pose, mon_now.req, mon_now.cnt,
                     mon_exp.vis, mon_exp.pose, mon_exp.req, mon_exp.cnt);
          end
        end
        prev_obs = mon_now;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3 clrn = 1'b0;
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
    mon_en = 1'b1;
    check("rst_visible", 32'(kong_visible), 32'd0);
    check("rst_pose",    32'(animation_state), 32'd0);
    check("rst_req",     32'(throw_req), 32'd0);
    check("rst_count",   32'(throw_count), 32'd0);
    check("posx",        32'(posx), 32'd20);
    check("posy",        32'(posy), 32'd40);

    // Play starts with no prior ticks: wait length 60 + 0x25 = 97.
    expect_obs(1'b1, 1'b0, 1'b0);
    isplay = 1'b1;
    step(1'b0, 1'b0);
    run_to_throw(97, 1'b0);

    // Acked throw, then a stray ack in WAIT must be ignored.
    m_cnt++;
    expect_obs(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("count_after_ack", 32'(throw_count), 32'd1);
    recover_to_wait(wl);
    run_to_throw(wl, 1'b1);

    // Timeout without ack.
    repeat (7) step(1'b1, 1'b0);
    expect_obs(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    recover_to_wait(wl);
    run_to_throw(wl, 1'b0);

    // Ack on the timeout tick: ack wins.
    repeat (7) step(1'b1, 1'b0);
    m_cnt++;
    expect_obs(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    recover_to_wait(wl);
    run_to_throw(wl, 1'b0);

    // Play drops together with ack: abort to IDLE, no increment, LFSR keeps running.
    expect_obs(1'b0, 1'b0, 1'b0);
    isplay = 1'b0;
    step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    wl = 60 + int'(m_lfsr[5:0]);
    expect_obs(1'b1, 1'b0, 1'b0);
    isplay = 1'b1;
    step(1'b0, 1'b0);
    run_to_throw(wl, 1'b0);

    // Fill the counter to 255, then one more ack wraps it.
    while (m_cnt != 8'd255) begin
      m_cnt++;
      expect_obs(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1);
      recover_to_wait(wl);
      run_to_throw(wl, 1'b0);
    end
    check("count_full", 32'(throw_count), 32'd255);
    m_cnt++;
    expect_obs(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("count_wrap", 32'(throw_count), 32'd0);
    recover_to_wait(wl);
    for (int i = 0; i < wl - 1; i++) step(1'b1, 1'b0);
    expect_obs(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0);

    // Asynchronous reset mid-WINDUP, away from any clock edge.
    #2;
    m_cnt = 8'd0;
    expect_obs(1'b0, 1'b0, 1'b0);
    clrn = 1'b0;
    #1;
    check("async_visible", 32'(kong_visible), 32'd0);
    check("async_pose",    32'(animation_state), 32'd0);
    check("async_req",     32'(throw_req), 32'd0);
    check("async_count",   32'(throw_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    isplay = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("expectations_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
